// File: rtl/pulse_counter_display_pkg.sv
// Shared types, segment table and sizing helpers
// for the multi-channel pulse counter display.
package pulse_counter_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_CHECK_PRESS,
    DB_PRESSED,
    DB_CHECK_RELEASE
  } db_state_t;

  // Active-low {g,f,e,d,c,b,a}, entry 0 on the right.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int width_of(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int db_cycles(input int f_hz,
                                   input int ms);
    return f_hz / 1000 * ms;
  endfunction

  function automatic int scan_cycles(input int f_hz,
                                     input int r_hz,
                                     input int n);
    int s;
    s = f_hz / (r_hz * n);
    return (s < 1) ? 1 : s;
  endfunction

endpackage

// File: rtl/pulse_counter_display_if.sv
// Seven-segment display bus: digit enables and
// segment lines, both active-low.
interface pulse_counter_display_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] en_disp;
  logic [7:0]      digit_out;

  modport master (output en_disp, digit_out);
  modport slave  (input  en_disp, digit_out);
endinterface

// File: rtl/pulse_counter_display_debounce.sv
// Per-button synchroniser and debounce FSM that
// emits one pulse per accepted press.
module btn_debounce_pulse
  import pulse_counter_pkg::*;
#(
  parameter int DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  // Pulse is registered, so stop one count early
  // to land the counter update on DB_CYCLES+3.
  localparam int LAST =
    (DB_CYCLES > 1) ? DB_CYCLES - 2 : 0;
  localparam int DW = width_of(LAST);
  localparam logic [DW-1:0] LAST_V = DW'(LAST);

  logic s1, s2;
  db_state_t state;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DB_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      unique case (state)
        DB_IDLE: begin
          if (!s2) begin
            state <= DB_CHECK_PRESS;
            cnt   <= '0;
          end
        end
        DB_CHECK_PRESS: begin
          if (s2) begin
            state <= DB_IDLE;
          end else if (cnt == LAST_V) begin
            state <= DB_PRESSED;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DB_PRESSED: begin
          if (s2) begin
            state <= DB_CHECK_RELEASE;
            cnt   <= '0;
          end
        end
        DB_CHECK_RELEASE: begin
          if (!s2) begin
            state <= DB_PRESSED;
          end else if (cnt == LAST_V) begin
            state <= DB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= DB_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_counter_display.sv
// N-channel debounced pulse counters with wrap or
// saturate, multiplexed onto a seven-segment display.
module pulse_counter_display
  import pulse_counter_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 12000000,
  parameter int DEBOUNCE_TIME_MS = 20,
  parameter int REFRESH_HZ       = 1000,
  parameter int N_CH             = 4,
  parameter int MAX_COUNT        = 15,
  parameter int WRAP             = 1,
  localparam int CW = width_of(MAX_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      btn_in,
  input  logic                 dir,
  input  logic                 clr,
  pulse_counter_display_if.master disp,
  output logic [N_CH*CW-1:0]   count_o,
  output logic [N_CH-1:0]      ovf_o,
  output logic                 rst_led
);
  localparam int DB =
    db_cycles(CLK_FREQ_HZ, DEBOUNCE_TIME_MS);
  localparam int SC =
    scan_cycles(CLK_FREQ_HZ, REFRESH_HZ, N_CH);
  localparam int SW = width_of(SC - 1);
  localparam int IW = width_of(N_CH - 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_COUNT);

  logic [N_CH-1:0] pulse;
  logic [CW-1:0]   count_q [N_CH];
  logic [N_CH-1:0] ovf_q;
  logic [SW-1:0]   scan_cnt;
  logic [IW-1:0]   idx;
  logic [N_CH-1:0] en_q;
  logic [7:0]      seg_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_pulse #(
      .DB_CYCLES(DB)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_in[i]),
      .pulse(pulse[i])
    );
    assign count_o[i*CW +: CW] = count_q[i];
  end

  assign ovf_o   = ovf_q;
  assign rst_led = ~rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
      ovf_q <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (pulse[i] && !dir) begin
          if (count_q[i] == MAXC) begin
            ovf_q[i]   <= 1'b1;
            count_q[i] <= (WRAP != 0) ? '0 : MAXC;
          end else begin
            count_q[i] <= count_q[i] + 1'b1;
          end
        end else if (pulse[i]) begin
          if (count_q[i] == '0) begin
            ovf_q[i]   <= 1'b1;
            count_q[i] <= (WRAP != 0) ? MAXC : '0;
          end else begin
            count_q[i] <= count_q[i] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      en_q     <= '1;
      seg_q    <= 8'hFF;
    end else begin
      en_q  <= ~(N_CH'(1) << idx);
      seg_q <= {~ovf_q[idx],
                SEG_LUT[4'(count_q[idx])]};
      if (scan_cnt == SW'(SC - 1)) begin
        scan_cnt <= '0;
        idx <= (idx == IW'(N_CH - 1)) ?
               '0 : idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  assign disp.en_disp   = en_q;
  assign disp.digit_out = seg_q;

endmodule

// File: tb/tb_pulse_counter_display.sv
// Bench for pulse_counter_display: wrap and
// saturate instances driven in parallel.
module tb_pulse_counter_display;
  localparam int F = 100000;
  localparam int N = 4;
  localparam int M = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dir = 1'b0;
  logic clr = 1'b0;
  logic [3:0] btn_in = 4'hF;
  logic [15:0] cnt_w, cnt_s;
  logic [3:0] ovf_w, ovf_s;
  logic led_w, led_s;
  logic [39:0] obs;

  always #5 clk = ~clk;

  pulse_counter_display_if #(.N_CH(N)) disp_w ();
  pulse_counter_display_if #(.N_CH(N)) disp_s ();

  pulse_counter_display #(
    .CLK_FREQ_HZ(F), .DEBOUNCE_TIME_MS(1),
    .REFRESH_HZ(1000), .N_CH(N),
    .MAX_COUNT(M), .WRAP(1)
  ) dut_w (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .dir(dir), .clr(clr), .disp(disp_w),
    .count_o(cnt_w), .ovf_o(ovf_w),
    .rst_led(led_w)
  );

  pulse_counter_display #(
    .CLK_FREQ_HZ(F), .DEBOUNCE_TIME_MS(1),
    .REFRESH_HZ(1000), .N_CH(N),
    .MAX_COUNT(M), .WRAP(0)
  ) dut_s (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .dir(dir), .clr(clr), .disp(disp_s),
    .count_o(cnt_s), .ovf_o(ovf_s),
    .rst_led(led_s)
  );

  assign obs = {cnt_w, cnt_s, ovf_w, ovf_s};

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  int tests = 0;
  int fails = 0;
  int mw[4];
  int ms[4];
  logic [3:0] ow, os;
  logic [39:0] exp_q[$];
  logic [39:0] e;

  function automatic logic [39:0] snap();
    logic [15:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a[i*4 +: 4] = 4'(mw[i]);
      b[i*4 +: 4] = 4'(ms[i]);
    end
    return {a, b, ow, os};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      mw[i] = 0;
      ms[i] = 0;
    end
    ow = '0;
    os = '0;
  endfunction

  function automatic void model_step(int ch, logic d);
    if (!d) begin
      if (mw[ch] == M) begin
        ow[ch] = 1'b1; mw[ch] = 0;
      end else mw[ch]++;
      if (ms[ch] == M) os[ch] = 1'b1;
      else ms[ch]++;
    end else begin
      if (mw[ch] == 0) begin
        ow[ch] = 1'b1; mw[ch] = M;
      end else mw[ch]--;
      if (ms[ch] == 0) os[ch] = 1'b1;
      else ms[ch]--;
    end
  endfunction

  task automatic start_press(logic [3:0] mask,
                             logic d);
    @(negedge clk);
    dir = d;
    btn_in = btn_in & ~mask;
    for (int i = 0; i < 4; i++)
      if (mask[i]) model_step(i, d);
    exp_q.push_back(snap());
  endtask

  task automatic release_btn();
    repeat (17) @(posedge clk);
    @(negedge clk);
    btn_in = 4'hF;
    repeat (120) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs !== 40'h0) begin
      fails++;
      $display("FAIL rst_counts got %h exp 0", obs);
    end
    tests++;
    if ({disp_w.en_disp, disp_w.digit_out,
         led_w} !== 13'h1FFF) begin
      fails++;
      $display("FAIL rst_disp got %h %h %b",
               disp_w.en_disp, disp_w.digit_out, led_w);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({disp_w.en_disp, disp_s.en_disp, led_s}
        !== 9'b1110_1110_0) begin
      fails++;
      $display("FAIL first_scan got %b %b %b",
               disp_w.en_disp, disp_s.en_disp, led_s);
    end
  endtask

  task automatic test_single_press();
    logic [39:0] pre;
    pre = snap();
    start_press(4'b0001, 1'b0);
    repeat (102) @(posedge clk);
    #1;
    tests++;
    if (obs !== pre) begin
      fails++;
      $display("FAIL early_count got %h exp %h", obs, pre);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL latency got %h exp %h", obs, e);
    end
    release_btn();
    tests++;
    if (obs !== snap()) begin
      fails++;
      $display("FAIL release got %h exp %h", obs, snap());
    end
  endtask

  task automatic test_up_overflow();
    int n;
    for (int k = 0; k < 16; k++) begin
      start_press(4'b0010, 1'b0);
      repeat (103) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL up%0d got %h exp %h", k, obs, e);
      end
      release_btn();
    end
    tests++;
    if ({cnt_w[7:4], ovf_w[1], cnt_s[7:4], ovf_s[1]}
        !== 10'b0000_1_1111_1) begin
      fails++;
      $display("FAIL up_ovf got %h %b %h %b",
               cnt_w[7:4], ovf_w[1], cnt_s[7:4], ovf_s[1]);
    end
    n = 0;
    while (disp_w.en_disp !== 4'b1101 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if ({disp_w.en_disp, disp_w.digit_out} !==
        {4'b1101, ~ow[1], SEG[mw[1]]}) begin
      fails++;
      $display("FAIL digit1_w got %b %h exp %h",
               disp_w.en_disp, disp_w.digit_out,
               {~ow[1], SEG[mw[1]]});
    end
    tests++;
    if ({disp_s.en_disp, disp_s.digit_out} !==
        {4'b1101, ~os[1], SEG[ms[1]]}) begin
      fails++;
      $display("FAIL digit1_s got %b %h exp %h",
               disp_s.en_disp, disp_s.digit_out,
               {~os[1], SEG[ms[1]]});
    end
  endtask

  task automatic test_down_underflow();
    start_press(4'b0100, 1'b1);
    repeat (103) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL down got %h exp %h", obs, e);
    end
    release_btn();
    tests++;
    if ({cnt_w[11:8], ovf_w[2], cnt_s[11:8], ovf_s[2]}
        !== 10'b1111_1_0000_1) begin
      fails++;
      $display("FAIL down_ovf got %h %b %h %b",
               cnt_w[11:8], ovf_w[2], cnt_s[11:8], ovf_s[2]);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      btn_in[3] = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      btn_in[3] = 1'b1;
      repeat (10) @(posedge clk);
    end
    repeat (120) @(posedge clk);
    #1;
    tests++;
    if (obs !== snap()) begin
      fails++;
      $display("FAIL glitch got %h exp %h", obs, snap());
    end
    start_press(4'b1000, 1'b0);
    repeat (103) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL stable got %h exp %h", obs, e);
    end
    release_btn();
  endtask

  task automatic test_back_to_back();
    logic [39:0] pre;
    pre = snap();
    start_press(4'hF, 1'b0);
    repeat (102) @(posedge clk);
    #1;
    tests++;
    if (obs !== pre) begin
      fails++;
      $display("FAIL all_early got %h exp %h", obs, pre);
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL all_same got %h exp %h", obs, e);
    end
    release_btn();
  endtask

  task automatic test_clr();
    @(negedge clk);
    dir = 1'b0;
    btn_in[0] = 1'b0;
    repeat (102) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    model_clear();
    exp_q.push_back(snap());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL clr got %h exp %h", obs, e);
    end
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (obs !== snap()) begin
      fails++;
      $display("FAIL clr_lost got %h exp %h", obs, snap());
    end
    release_btn();
  endtask

  task automatic test_reset_abort();
    start_press(4'b0001, 1'b0);
    void'(exp_q.pop_back());
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    tests++;
    if ({obs, disp_w.en_disp, disp_w.digit_out, led_w}
        !== {40'h0, 13'h1FFF}) begin
      fails++;
      $display("FAIL mid_rst got %h %h %h", obs,
               disp_w.en_disp, disp_w.digit_out);
    end
    @(negedge clk);
    btn_in = 4'b1101;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_step(1, 1'b0);
    exp_q.push_back(snap());
    repeat (103) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests++;
    if (obs !== e) begin
      fails++;
      $display("FAIL held_rst got %h exp %h", obs, e);
    end
    release_btn();
    repeat (100) @(posedge clk);
    #1;
    tests++;
    if (obs !== snap()) begin
      fails++;
      $display("FAIL held_once got %h exp %h", obs, snap());
    end
  endtask

  task automatic test_scan();
    logic [3:0] last, oh;
    int n, k, ch;
    for (int p = 0; p < 5; p++) begin
      start_press(4'b0001, 1'b0);
      repeat (103) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests++;
      if (obs !== e) begin
        fails++;
        $display("FAIL pre_scan%0d got %h exp %h", p, obs, e);
      end
      release_btn();
    end
    @(negedge clk);
    last = disp_w.en_disp;
    n = 0;
    while (disp_w.en_disp === last && n < 100) begin
      @(negedge clk);
      n++;
    end
    k = -1;
    for (int j = 0; j < 4; j++) begin
      oh = 4'b0001 << j;
      if (disp_w.en_disp === ~oh) k = j;
    end
    tests++;
    if (k < 0) begin
      fails++;
      $display("FAIL scan_sync got %b", disp_w.en_disp);
      k = 0;
    end
    for (int d = 0; d < 8; d++) begin
      ch = (k + d) % 4;
      oh = 4'b0001 << ch;
      for (int c = 0; c < 25; c++) begin
        tests++;
        if ({disp_w.en_disp, disp_w.digit_out,
             disp_s.en_disp, disp_s.digit_out} !==
            {~oh, ~ow[ch], SEG[mw[ch]],
             ~oh, ~os[ch], SEG[ms[ch]]}) begin
          fails++;
          $display("FAIL scan d%0d c%0d got %b %h exp %b %h",
                   d, c, disp_w.en_disp, disp_w.digit_out,
                   ~oh, {~ow[ch], SEG[mw[ch]]});
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_single_press();
    test_up_overflow();
    test_down_underflow();
    test_glitch();
    test_back_to_back();
    test_clr();
    test_reset_abort();
    test_scan();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
